vdc_init_seq: RTL and testbench

Bus initiator that programs the C128 VDC through its two-port CPU interface: the register-select port (rs=0) and the data port (rs=1). On a start pulse it writes the power-on register table for the selected chip version and video standard, then optionally clears display RAM by block fill. Between fill bursts it polls the status register busy bit. It sits between the core's reset/boot control and the VDC's cs/rs/we/db_in/db_out ports, muxed ahead of the CPU bus while active.

---
 rtl/vdc_init_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_vdc_init_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdc_init_seq.sv
// Boot-time VDC programmer: writes the power-on register table through the
// select/data port pair, then optionally block-fills display RAM while polling busy.
module vdc_init_seq #(
  parameter int          CLEAR_BLOCKS = 64,
  parameter logic [7:0]  FILL_BYTE    = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enableBus,
  input  logic       start,
  input  logic [1:0] version,
  input  logic       pal,
  input  logic       ram64k,
  output logic       cs,
  output logic       rs,
  output logic       we,
  output logic [7:0] db_out,
  input  logic [7:0] db_in,
  output logic       active,
  output logic       done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEL    = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_POLL   = 3'd3;
  localparam logic [2:0] S_SAMPLE = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;

  localparam logic [15:0] NBURST    = 16'(CLEAR_BLOCKS);
  localparam logic        HAS_CLEAR = (CLEAR_BLOCKS != 0);

  logic [2:0]  state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [15:0] burst_q, burst_d;
  logic        ver2_q, ver2_d, ver0_q, ver0_d, pal_q, pal_d, ram_q, ram_d;
  logic        started_q, started_d;
  logic        cs_q, cs_d, rs_q, rs_d, we_q, we_d;
  logic [7:0]  db_q, db_d;
  logic        active_q, active_d, done_q, done_d;

  logic [5:0]  tlen;
  logic [7:0]  cur_reg, cur_val;
  logic        unused_db;

  assign unused_db = ^db_in[6:0];

  // Table slots skip R16-R19 and R30-R33, so the register number is a piecewise offset.
  function automatic logic [7:0] tbl_reg(input logic [5:0] i);
    if (i < 6'd16)      return {2'b00, i};
    else if (i < 6'd26) return {2'b00, i} + 8'd4;
    else                return {2'b00, i} + 8'd8;
  endfunction

  function automatic logic [7:0] tbl_val(input logic [7:0] r, input logic p,
                                         input logic v0, input logic rm);
    case (r)
      8'd0:    return 8'h7E;
      8'd1:    return 8'h50;
      8'd2:    return 8'h66;
      8'd3:    return 8'h49;
      8'd4:    return p ? 8'h27 : 8'h20;
      8'd6:    return 8'h19;
      8'd7:    return p ? 8'h20 : 8'h1D;
      8'd9:    return 8'h07;
      8'd10:   return 8'h20;
      8'd11:   return 8'h07;
      8'd20:   return 8'h08;
      8'd22:   return 8'h78;
      8'd23:   return 8'h08;
      8'd24:   return 8'h20;
      8'd25:   return v0 ? 8'h40 : 8'h47;
      8'd26:   return 8'hF0;
      8'd28:   return {3'b001, rm, 4'b0000};
      8'd29:   return 8'h07;
      8'd34:   return 8'h7D;
      8'd35:   return 8'h64;
      8'd36:   return 8'h05;
      8'd37:   return 8'hC0;
      default: return 8'h00;
    endcase
  endfunction

  // Indices past the table walk R18, R19, R31, then R30 repeats for every burst.
  always_comb begin
    tlen    = ver2_q ? 6'd30 : 6'd29;
    cur_reg = 8'd30;
    cur_val = 8'hFF;
    if (idx_q < tlen) begin
      cur_reg = tbl_reg(idx_q);
      cur_val = tbl_val(cur_reg, pal_q, ver0_q, ram_q);
    end else if (idx_q == tlen) begin
      cur_reg = 8'd18;
      cur_val = 8'h00;
    end else if (idx_q == tlen + 6'd1) begin
      cur_reg = 8'd19;
      cur_val = 8'h00;
    end else if (idx_q == tlen + 6'd2) begin
      cur_reg = 8'd31;
      cur_val = FILL_BYTE;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    burst_d   = burst_q;
    ver2_d    = ver2_q;
    ver0_d    = ver0_q;
    pal_d     = pal_q;
    ram_d     = ram_q;
    started_d = started_q;
    cs_d      = cs_q;
    rs_d      = rs_q;
    we_d      = we_q;
    db_d      = db_q;
    active_d  = active_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d   = S_SEL;
        active_d  = 1'b1;
        idx_d     = 6'd0;
        burst_d   = 16'd0;
        started_d = 1'b0;
        ver2_d    = version[1];
        ver0_d    = (version == 2'd0);
        pal_d     = pal;
        ram_d     = ram64k;
      end
      S_SEL: begin
        // Only the very first access waits for a strobe; later ones follow the capture clock.
        if (!cs_q) begin
          if (started_q || enableBus) begin
            cs_d      = 1'b1;
            rs_d      = 1'b0;
            we_d      = 1'b1;
            db_d      = cur_reg;
            started_d = 1'b1;
          end
        end else if (enableBus) begin
          cs_d    = 1'b0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (!cs_q) begin
          cs_d = 1'b1;
          rs_d = 1'b1;
          we_d = 1'b1;
          db_d = cur_val;
        end else if (enableBus) begin
          cs_d = 1'b0;
          if (idx_q < tlen - 6'd1 || (HAS_CLEAR && idx_q < tlen + 6'd2)) begin
            idx_d   = idx_q + 6'd1;
            state_d = S_SEL;
          end else if (!HAS_CLEAR) begin
            state_d = S_FIN;
          end else begin
            if (idx_q == tlen + 6'd2) idx_d = idx_q + 6'd1;
            else                      burst_d = burst_q + 16'd1;
            state_d = S_POLL;
          end
        end
      end
      S_POLL: begin
        if (!cs_q) begin
          cs_d = 1'b1;
          rs_d = 1'b0;
          we_d = 1'b0;
        end else if (enableBus) begin
          cs_d    = 1'b0;
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (!db_in[7])              state_d = S_POLL;
        else if (burst_q == NBURST) state_d = S_FIN;
        else                        state_d = S_SEL;
      end
      S_FIN: begin
        state_d  = S_IDLE;
        active_d = 1'b0;
        done_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 6'd0;
      burst_q   <= 16'd0;
      ver2_q    <= 1'b0;
      ver0_q    <= 1'b0;
      pal_q     <= 1'b0;
      ram_q     <= 1'b0;
      started_q <= 1'b0;
      cs_q      <= 1'b0;
      rs_q      <= 1'b0;
      we_q      <= 1'b0;
      db_q      <= 8'h00;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      burst_q   <= burst_d;
      ver2_q    <= ver2_d;
      ver0_q    <= ver0_d;
      pal_q     <= pal_d;
      ram_q     <= ram_d;
      started_q <= started_d;
      cs_q      <= cs_d;
      rs_q      <= rs_d;
      we_q      <= we_d;
      db_q      <= db_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  assign cs     = cs_q;
  assign rs     = rs_q;
  assign we     = we_q;
  assign db_out = db_q;
  assign active = active_q;
  assign done   = done_q;

endmodule

// File: tb/tb_vdc_init_seq.sv
// Bench for vdc_init_seq: two instances (no clear / two-burst clear) share stimulus;
// expected VDC accesses are queued per run and popped by a monitor on every captured access.
module tb_vdc_init_seq;

  logic       clk = 1'b0;
  logic       reset, enableBus, start, pal, ram64k;
  logic [1:0] version;
  logic       cs0, rs0, we0, active0, done0;
  logic       cs1, rs1, we1, active1, done1;
  logic [7:0] db_out0, db_out1, db_in0, db_in1;

  always #5 clk = ~clk;

  vdc_init_seq #(.CLEAR_BLOCKS(0)) dut0 (
    .clk(clk), .reset(reset), .enableBus(enableBus), .start(start),
    .version(version), .pal(pal), .ram64k(ram64k),
    .cs(cs0), .rs(rs0), .we(we0), .db_out(db_out0), .db_in(db_in0),
    .active(active0), .done(done0));

  vdc_init_seq #(.CLEAR_BLOCKS(2), .FILL_BYTE(8'h20)) dut1 (
    .clk(clk), .reset(reset), .enableBus(enableBus), .start(start),
    .version(version), .pal(pal), .ram64k(ram64k),
    .cs(cs1), .rs(rs1), .we(we1), .db_out(db_out1), .db_in(db_in1),
    .active(active1), .done(done1));

  typedef struct packed {logic rs; logic we; logic [7:0] d;} acc_t;

  acc_t       q0[$], q1[$];
  int         n_tests = 0, n_fail = 0;
  int         done_cnt[2];
  int         acc0 = 0;
  int         busy_cfg = 5;
  int         polls = 0;
  bit         mon_en = 0, en_hi = 0;
  logic [7:0] sel0 = 8'h00, sel1 = 8'h00;

  assign db_in0 = 8'h80;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Power-on values straight from the register table.
  function automatic logic [7:0] regval(input int r, input int v, input bit p, input bit rm);
    case (r)
      0: return 8'h7E;  1: return 8'h50;  2: return 8'h66;  3: return 8'h49;
      4: return p ? 8'h27 : 8'h20;        6: return 8'h19;
      7: return p ? 8'h20 : 8'h1D;        9: return 8'h07;
      10: return 8'h20; 11: return 8'h07; 20: return 8'h08; 22: return 8'h78;
      23: return 8'h08; 24: return 8'h20; 25: return (v == 0) ? 8'h40 : 8'h47;
      26: return 8'hF0; 28: return rm ? 8'h30 : 8'h20;      29: return 8'h07;
      34: return 8'h7D; 35: return 8'h64; 36: return 8'h05; 37: return 8'hC0;
      default: return 8'h00;
    endcase
  endfunction

  task automatic push(input int k, input logic r, input logic w, input logic [7:0] d);
    acc_t e;
    e.rs = r; e.we = w; e.d = d;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic push_wr(input int k, input int r, input logic [7:0] v);
    push(k, 1'b0, 1'b1, 8'(r));
    push(k, 1'b1, 1'b1, v);
  endtask

  task automatic build(input int ver, input bit p, input bit rm, input int busy);
    int v;
    v = (ver == 3) ? 2 : ver;
    q0.delete(); q1.delete();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 38; r++) begin
        if ((r >= 16 && r <= 19) || (r >= 30 && r <= 33)) continue;
        if (r == 37 && v != 2) continue;
        push_wr(k, r, regval(r, v, p, rm));
      end
    push_wr(1, 18, 8'h00);
    push_wr(1, 19, 8'h00);
    push_wr(1, 31, 8'h20);
    push(1, 1'b0, 1'b0, 8'h00);          // status is ready right after the first fill byte
    for (int b = 0; b < 2; b++) begin
      push_wr(1, 30, 8'hFF);
      for (int i = 0; i <= busy; i++) push(1, 1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic mon_one(input int k, input logic c, input logic r, input logic w,
                         input logic [7:0] d, input logic dn, input logic act);
    acc_t e;
    int   sz;
    if (c && enableBus) begin
      if (k == 0) acc0++;
      sz = (k == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dut%0d_unexpected_access: got rs=%0b we=%0b db=%0h, required no access",
                 k, r, w, d);
      end else begin
        if (k == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("dut%0d_rs", k), r, e.rs);
        check($sformatf("dut%0d_we", k), w, e.we);
        if (e.we) check($sformatf("dut%0d_db rs=%0b", k, e.rs), d, e.d);
      end
    end
    if (dn) begin
      done_cnt[k]++;
      sz = (k == 0) ? q0.size() : q1.size();
      check($sformatf("dut%0d_done_pending_accesses", k), sz, 0);
      check($sformatf("dut%0d_done_active", k), act, 0);
      check($sformatf("dut%0d_done_cs", k), c, 0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        mon_one(0, cs0, rs0, we0, db_out0, done0, active0);
        mon_one(1, cs1, rs1, we1, db_out1, done1, active1);
      end
    end
  end

  // VDC side: tracks selected register; status reads busy for busy_cfg polls after each R30 write.
  initial begin
    db_in1 = 8'h00;
    forever begin
      @(negedge clk);
      if (cs0 && enableBus && we0 && !rs0) sel0 = db_out0;
      if (cs1 && enableBus) begin
        if (we1 && !rs1) sel1 = db_out1;
        else if (we1 && rs1 && sel1 == 8'd30) polls = 0;
        else if (we1 && rs1 && sel1 == 8'd31) polls = busy_cfg;
        else if (!we1) begin
          db_in1 = (polls < busy_cfg) ? 8'h15 : 8'h80;
          polls++;
        end
      end
    end
  end

  initial begin
    enableBus = 1'b0;
    forever begin
      @(posedge clk); #1;
      enableBus = en_hi ? 1'b1 : ($urandom_range(0, 1) == 1);
    end
  end

  task automatic run_seq(input int ver, input bit p, input bit rm, input int busy, input bit mid);
    int  b0, b1;
    bit  fin, did;
    build(ver, p, rm, busy);
    busy_cfg = busy;
    b0 = done_cnt[0]; b1 = done_cnt[1];
    did = 0;
    @(posedge clk); #1;
    version = 2'(ver); pal = p; ram64k = rm; start = 1'b1;
    acc0 = 0;
    @(posedge clk); #1;
    start = 1'b0;
    version = 2'($urandom); pal = 1'($urandom);
    check("dut0_active_rise", active0, 1);
    check("dut1_active_rise", active1, 1);
    fin = 0;
    for (int t = 0; t < 8000 && !fin; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (mid && !did && acc0 >= 20) begin
        start = 1'b1;
        did = 1;
      end
      fin = (done_cnt[0] > b0) && (done_cnt[1] > b1);
    end
    start = 1'b0;
    check($sformatf("seq_complete v%0d", ver), fin, 1);
    repeat (10) @(posedge clk);
    #2;
    check("dut0_done_once", done_cnt[0] - b0, 1);
    check("dut1_done_once", done_cnt[1] - b1, 1);
    check("dut0_queue_drained", q0.size(), 0);
    check("dut1_queue_drained", q1.size(), 0);
    check("dut0_active_end", active0, 0);
    check("dut1_active_end", active1, 0);
  endtask

  task automatic reset_mid_test();
    int  b0;
    bit  hit;
    build(0, 0, 0, 3);
    busy_cfg = 3;
    @(posedge clk); #1;
    version = 2'd0; pal = 1'b0; ram64k = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 0;
    for (int t = 0; t < 3000 && !hit; t++) begin
      @(posedge clk); #2;
      hit = cs0 && rs0 && we0 && (sel0 == 8'd12);
    end
    check("reached_r12_data", hit, 1);
    mon_en = 0;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    check("rst_mid_cs0", cs0, 0);
    check("rst_mid_active0", active0, 0);
    check("rst_mid_cs1", cs1, 0);
    check("rst_mid_active1", active1, 0);
    check("rst_mid_db_out0", db_out0, 0);
    q0.delete(); q1.delete();
    b0 = done_cnt[0];
    mon_en = 1;
    repeat (60) @(posedge clk);
    #2;
    check("rst_mid_no_done", done_cnt[0] - b0, 0);
    check("rst_mid_still_idle", active0, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; version = 2'd0; pal = 1'b0; ram64k = 1'b0;
    done_cnt[0] = 0; done_cnt[1] = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_cs0", cs0, 0);         check("rst_cs1", cs1, 0);
    check("rst_rs0", rs0, 0);         check("rst_rs1", rs1, 0);
    check("rst_we0", we0, 0);         check("rst_we1", we1, 0);
    check("rst_db0", db_out0, 0);     check("rst_db1", db_out1, 0);
    check("rst_active0", active0, 0); check("rst_active1", active1, 0);
    check("rst_done0", done0, 0);     check("rst_done1", done1, 0);
    reset = 1'b0;
    mon_en = 1;

    begin
      int s;
      s = 0;
      for (int t = 0; t < 2000 && s < 100; t++) begin
        @(posedge clk); #2;
        if (enableBus) s++;
      end
      check("idle_strobes_seen", s, 100);
      check("idle_active0", active0, 0);
      check("idle_done_count", done_cnt[0] + done_cnt[1], 0);
    end

    run_seq(0, 0, 0, 5, 0);
    run_seq(2, 1, 1, 5, 0);
    run_seq(1, 0, 1, 4, 1);
    en_hi = 1;
    run_seq(3, 1, 0, 2, 0);
    en_hi = 0;
    for (int i = 0; i < 3; i++)
      run_seq($urandom_range(0, 3), 1'($urandom), 1'($urandom), $urandom_range(0, 5), 0);
    reset_mid_test();
    run_seq(0, 0, 0, 5, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
